// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b widths and the L1/L2 arbiter state type
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_c_block;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RETURN = 2'd2
    } lc3b_arb_state;

    // Grant encoding doubles as the marmux select value.
    localparam logic GRANT_ICACHE = 1'b0;
    localparam logic GRANT_DCACHE = 1'b1;

endpackage

// File: rtl/register.sv
// rtl/register.sv - loadable register with asynchronous clear
module register #(
    parameter int width = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] in,
    output logic [width-1:0] out
);

    logic [width-1:0] data_q;
    logic [width-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: rtl/arbiter_control.sv
// rtl/arbiter_control.sv - round-robin icache/dcache arbiter control and L2 read return
module arbiter_control
    import lc3b_types::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         icache_pmem_read,
    output logic         icache_pmem_resp,
    output logic [127:0] icache_pmem_rdata,
    input  logic         dcache_pmem_read,
    input  logic         dcache_pmem_write,
    output logic         dcache_pmem_resp,
    output logic [127:0] dcache_pmem_rdata,
    output logic         l2_read,
    output logic         l2_write,
    input  logic         l2_resp,
    input  logic [127:0] l2_rdata,
    output logic         ld_mar,
    output logic         ld_mdr,
    output logic         marmux_sel
);

    lc3b_arb_state state_q, state_d;
    logic          grant_q, grant_d;
    logic          write_q, write_d;
    logic          last_grant_q, last_grant_d;

    logic          pend_i;
    logic          pend_d;
    logic          grant_sel;
    logic          buf_load;
    lc3b_c_block   buf_out;

    assign pend_i = icache_pmem_read;
    assign pend_d = dcache_pmem_read | dcache_pmem_write;
    // On a tie the cache that lost last time wins; otherwise the lone requester.
    assign grant_sel = (pend_i & pend_d) ? ~last_grant_q : pend_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_ICACHE;
            write_q      <= 1'b0;
            last_grant_q <= GRANT_DCACHE;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            write_q      <= write_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        write_d      = write_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pend_i | pend_d) begin
                    state_d      = ISSUE;
                    grant_d      = grant_sel;
                    write_d      = (grant_sel == GRANT_DCACHE) & dcache_pmem_write;
                    last_grant_d = grant_sel;
                end
            end
            ISSUE: begin
                if (l2_resp) begin
                    state_d = RETURN;
                end
            end
            RETURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_mar           = 1'b0;
        ld_mdr           = 1'b0;
        marmux_sel       = 1'b0;
        l2_read          = 1'b0;
        l2_write         = 1'b0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                // Grant strobes depend on live requests, so hold them off while reset is asserted.
                if ((pend_i | pend_d) & ~reset) begin
                    ld_mar     = 1'b1;
                    marmux_sel = grant_sel;
                    ld_mdr     = (grant_sel == GRANT_DCACHE) & dcache_pmem_write;
                end
            end
            ISSUE: begin
                l2_read  = ~write_q;
                l2_write = write_q;
            end
            RETURN: begin
                icache_pmem_resp = (grant_q == GRANT_ICACHE);
                dcache_pmem_resp = (grant_q == GRANT_DCACHE);
            end
            default: ;
        endcase
    end

    assign buf_load = (state_q == ISSUE) & l2_resp & ~write_q;

    register #(.width(128)) return_buf (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .in    (l2_rdata),
        .out   (buf_out)
    );

    assign icache_pmem_rdata = buf_out;
    assign dcache_pmem_rdata = buf_out;

endmodule
